fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter ROM_WORDS, default 32, instruction ROM depth in 32-bit words; fixed at 32 to match the 5-bit ROM address.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/jump redirect request.
REQ-006 redirect_pc  input  32  redirect target byte address.
REQ-007 instr_ready  input  1  decode stage accepts instr this cycle.
REQ-008 rom_data  input  32  ROM read data, valid one cycle after rom_rd_en.
REQ-009 rom_rd_en  output  1  ROM read strobe.
REQ-010 rom_address  output  5  ROM word index.
REQ-011 program_counter  output  32  byte address of the instruction being fetched or held.
REQ-012 instr  output  32  fetched instruction.
REQ-013 instr_valid  output  1  instr holds a valid instruction.
REQ-014 fetch_fault  output  1  sticky out-of-range fault; see REQ-031.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, VALID and FAULT, encoded in 3 bits.
REQ-016 rom_address SHALL equal program_counter[6:2] combinationally: word index, byte offset discarded.
REQ-017 IDLE: outputs inactive; next state is ISSUE.
REQ-018 ISSUE: rom_rd_en=1 for exactly one cycle; next state is WAIT.
REQ-019 WAIT: rom_rd_en=0; instr captures rom_data at the end of the cycle; next state is VALID.
REQ-020 VALID: instr_valid=1, and instr and program_counter SHALL stay stable until instr_ready=1.
REQ-021 VALID handshake (instr_valid & instr_ready): program_counter increments by 4, modulo 2^32; next state is ISSUE.
REQ-022 Latency from ISSUE to instr_valid SHALL be 2 cycles; peak throughput is one instruction per 3 cycles.
REQ-023 redirect_valid=1 in any state SHALL, at the next edge:
- load program_counter with {redirect_pc[31:2],2'b00};
- clear instr_valid and fetch_fault;
- enter ISSUE.
REQ-024 Redirect SHALL take priority over a simultaneous handshake; the handshaked instruction counts as consumed and no PC+4 is applied.
REQ-025 A redirect during WAIT SHALL discard the in-flight rom_data; it SHALL never appear on instr.
REQ-026 A misaligned redirect_pc SHALL have bits [1:0] forced to zero; no fault is raised.

Reset
REQ-027 Reset SHALL have priority over redirect and handshake.
REQ-028 On reset: state=IDLE, program_counter=RESET_PC, instr=0, instr_valid=0, rom_rd_en=0, fetch_fault=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abandon any in-flight read and take effect at the next edge.

Configuration
REQ-030 Macro FETCH_BOUNDS_CHECK_EN selects out-of-range handling for program_counter.
REQ-031 With FETCH_BOUNDS_CHECK_EN defined, entering ISSUE with program_counter >= 4*ROM_WORDS (128) SHALL, instead of reading:
- go to FAULT;
- keep rom_rd_en=0;
- set fetch_fault=1.
FAULT SHALL be left only by redirect or reset.
REQ-032 Without FETCH_BOUNDS_CHECK_EN, fetch_fault SHALL be tied 0, FAULT SHALL be unreachable, and addresses SHALL wrap modulo 32 words via REQ-016.

Structure
REQ-033 The shared cpu package SHALL hold:
- the fetch state enum typedef;
- constants ROM_ADDR_W=5, INSTR_W=32, PC_STEP=4.
REQ-034 The ROM address mapping SHALL be a sub-module named pc_rom_index (program_counter in, 5-bit index out); the FSM and registers stay in fetch_controller.

Verification
REQ-035 Reset then release, RESET_PC=0, ROM[0]=32'hDEAD_BEEF, instr_ready=1: rom_rd_en at cycle 1; instr_valid=1 with instr=DEADBEEF at cycle 3; program_counter=4 at cycle 4.
REQ-036 Backpressure: instr_ready=0 for 5 cycles in VALID: instr, program_counter and instr_valid constant; no rom_rd_en.
REQ-037 Redirect to 32'h0000_0013 during WAIT: stale data dropped; next ISSUE uses program_counter=0x10, rom_address=4.
REQ-038 Redirect to 0x40 in the same cycle as a handshake at PC 0x8: next program_counter=0x40, not 0xC.
REQ-039 PC reaches 0x80:
- with FETCH_BOUNDS_CHECK_EN: fetch_fault=1 and no rom_rd_en until a redirect to 0x0 clears it;
- without it: rom_address=0 and fetch continues.
REQ-040 Reset asserted in VALID: next cycle instr_valid=0, program_counter=RESET_PC, state IDLE.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared CPU package: fetch state encoding and datapath constants.
package fetch_controller_pkg;

    localparam int unsigned ROM_ADDR_W = 5;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned PC_STEP    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_controller_pc_rom_index.sv
// PC to ROM word index mapping: byte offset dropped, upper bits ignored so
// addresses wrap modulo the ROM depth.
module pc_rom_index
    import fetch_controller_pkg::*;
(
    input  logic [31:0]           program_counter,
    output logic [ROM_ADDR_W-1:0] rom_address
);

    logic w_unused_bits;

    assign rom_address   = program_counter[ROM_ADDR_W+1:2];
    assign w_unused_bits = ^{program_counter[31:ROM_ADDR_W+2], program_counter[1:0]};

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one ROM read per instruction, holds the
// result for the decode handshake, and accepts redirects from any state.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (out-of-range PC faults).
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  instr_ready,
    input  logic [INSTR_W-1:0]    rom_data,
    output logic                  rom_rd_en,
    output logic [ROM_ADDR_W-1:0] rom_address,
    output logic [31:0]           program_counter,
    output logic [INSTR_W-1:0]    instr,
    output logic                  instr_valid,
    output logic                  fetch_fault
);

    if (ROM_WORDS != 32) begin : g_bad_depth
        $error("fetch_controller: ROM_WORDS must be 32 to match the 5-bit ROM address");
    end

    fetch_state_t       r_state;
    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;
    logic               r_rom_rd_en;

    logic               w_handshake;
    logic               w_enter_issue;
    logic [31:0]        w_issue_pc;
    logic               w_oob;

    // Every path into ISSUE (redirect, leaving IDLE, handshake) shares one
    // target PC so the bounds check sees exactly the address about to be read.
    assign w_handshake   = (r_state == ST_VALID) && instr_ready;
    assign w_enter_issue = redirect_valid || (r_state == ST_IDLE) || w_handshake;

    // Target PC for the next ISSUE; redirect beats the handshake increment.
    always_comb begin
        w_issue_pc = r_pc;
        if (redirect_valid) begin
            w_issue_pc = align_word(redirect_pc);
        end else if (w_handshake) begin
            w_issue_pc = r_pc + 32'(PC_STEP);
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    logic r_fetch_fault;

    assign w_oob = (w_issue_pc >= 32'(PC_STEP * ROM_WORDS));

    // Sticky fault flag, re-evaluated only when a new fetch is started.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_fault <= 1'b0;
        end else if (w_enter_issue) begin
            r_fetch_fault <= w_oob;
        end
    end

    assign fetch_fault = r_fetch_fault;
`else
    assign w_oob       = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Fetch FSM with registered strobe, instruction and valid outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_rom_rd_en   <= 1'b0;
        end else begin
            r_rom_rd_en <= 1'b0;
            if (w_enter_issue) begin
                r_pc          <= w_issue_pc;
                r_instr_valid <= 1'b0;
                if (w_oob) begin
                    r_state <= ST_FAULT;
                end else begin
                    r_state     <= ST_ISSUE;
                    r_rom_rd_en <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_ISSUE: r_state <= ST_WAIT;
                    ST_WAIT: begin
                        r_instr       <= rom_data;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_VALID;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    pc_rom_index u_pc_rom_index (
        .program_counter (r_pc),
        .rom_address     (rom_address)
    );

    assign rom_rd_en       = r_rom_rd_en;
    assign program_counter = r_pc;
    assign instr           = r_instr;
    assign instr_valid     = r_instr_valid;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vector table, a PC
// wrap/bounds sequence, then randomized traffic against a reference model.
module tb_fetch_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic [31:0] rom_data;
    logic        rom_rd_en;
    logic [4:0]  rom_address;
    logic [31:0] program_counter;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_fault;

    logic [31:0] rom [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_controller #(
        .RESET_PC  (RST_PC),
        .ROM_WORDS (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_ready     (instr_ready),
        .rom_data        (rom_data),
        .rom_rd_en       (rom_rd_en),
        .rom_address     (rom_address),
        .program_counter (program_counter),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .fetch_fault     (fetch_fault)
    );

    // Synchronous ROM: data valid the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom[rom_address];
        else           rom_data <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic rdv, input logic [31:0] rpc, input logic rdy);
        reset          = rst;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_rd, input logic e_v,
                              input logic [31:0] e_pc, input logic e_fault);
        check({tag, "_rd_en"}, 32'(rom_rd_en), 32'(e_rd));
        check({tag, "_valid"}, 32'(instr_valid), 32'(e_v));
        check({tag, "_pc"}, program_counter, e_pc);
        check({tag, "_addr"}, 32'(rom_address), 32'(e_pc[6:2]));
        check({tag, "_fault"}, 32'(fetch_fault), 32'(e_fault));
        if (e_v) check({tag, "_instr"}, instr, rom[e_pc[6:2]]);
    endtask

    // Reference model: tracks whether a fetch is active, how many cycles since
    // it was issued, and the PC; outputs follow from the fetch rules directly.
    bit          m_idle, m_fault;
    int          m_age;
    logic [31:0] m_pc;

    function automatic bit bounds_on();
`ifdef FETCH_BOUNDS_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_start();
        m_idle  = 1'b0;
        m_age   = 0;
        m_fault = bounds_on() && (m_pc >= 32'd128);
    endtask

    task automatic m_step(input logic rst, input logic rdv, input logic [31:0] rpc, input logic rdy);
        if (rst) begin
            m_idle = 1'b1; m_fault = 1'b0; m_age = 0; m_pc = RST_PC;
        end else if (rdv) begin
            m_pc = {rpc[31:2], 2'b00};
            m_start();
        end else if (m_idle) begin
            m_start();
        end else if (!m_fault) begin
            if (m_age >= 2) begin
                if (rdy) begin
                    m_pc = m_pc + 32'd4;
                    m_start();
                end
            end else begin
                m_age++;
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_rd;
        logic        e_v;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [22];

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
        rom[0]  = 32'hDEAD_BEEF;
        rom[16] = 32'h57A1_E000;
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        // rst rdv rpc           rdy   rd   v    pc
        tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00};
        tbl[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00};
        tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h04};
        tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h04};
        tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h04};
        for (int i = 7; i <= 11; i++)
            tbl[i] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h04};
        tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h08};
        tbl[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h08};
        tbl[14] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h08};
        tbl[15] = '{1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h40};
        tbl[16] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h40};
        tbl[17] = '{1'b0, 1'b1, 32'h13, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[18] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h10};
        tbl[19] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h10};
        tbl[20] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, RST_PC};
        tbl[21] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, RST_PC};

        cyc();
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].rdv, tbl[i].rpc, tbl[i].rdy);
            cyc();
            check_outs($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_v, tbl[i].e_pc, 1'b0);
            if (tbl[i].rst) check($sformatf("vec%0d_reset_instr", i), instr, 32'h0);
        end

        // Misaligned redirect near the top of the ROM, then step past 0x7C.
        drive(1'b0, 1'b1, 32'h0000_007E, 1'b0);
        cyc(); check_outs("top_issue", 1'b1, 1'b0, 32'h7C, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(); check_outs("top_wait", 1'b0, 1'b0, 32'h7C, 1'b0);
        cyc(); check_outs("top_valid", 1'b0, 1'b1, 32'h7C, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_BOUNDS_CHECK_EN
        cyc(); check_outs("oob_fault", 1'b0, 1'b0, 32'h80, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(); check_outs("oob_hold", 1'b0, 1'b0, 32'h80, 1'b1);
        end
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        cyc(); check_outs("oob_clear", 1'b1, 1'b0, 32'h00, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
`else
        cyc(); check_outs("wrap_issue", 1'b1, 1'b0, 32'h80, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(); check_outs("wrap_wait", 1'b0, 1'b0, 32'h80, 1'b0);
        cyc(); check_outs("wrap_valid", 1'b0, 1'b1, 32'h80, 1'b0);
        check("wrap_instr_deadbeef", instr, 32'hDEAD_BEEF);
`endif

        // Randomized traffic against the reference model.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        cyc();
        m_step(1'b1, 1'b0, 32'h0, 1'b0);
        check_outs("rnd_reset", 1'b0, 1'b0, m_pc, 1'b0);
        for (int n = 0; n < 500; n++) begin
            logic        rst, rdv, rdy;
            logic [31:0] rpc;
            rst = ($urandom_range(0, 63) == 0);
            rdv = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 160));
            rdy = ($urandom_range(0, 2) != 0);
            drive(rst, rdv, rpc, rdy);
            cyc();
            m_step(rst, rdv, rpc, rdy);
            check_outs("rnd",
                       !m_idle && !m_fault && (m_age == 0),
                       !m_idle && !m_fault && (m_age >= 2),
                       m_pc, m_fault);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
